image_reflect_ctrl: RTL and testbench

Frame-level controller that sequences a reflection through an external single-port frame RAM.
- LOAD phase: accepts one ROWS x COLS frame of pixels in raster order on a valid/ready stream and writes each pixel to the RAM.
- DRAIN phase: reads the frame back using mirrored addresses and emits it on an output valid/ready stream.
- Sits between the pixel source (file reader / upstream filter) and the downstream writer stage of the image pipeline.

---
 rtl/image_pkg.sv | 24 ++
 rtl/reflect_out_buf.sv | 52 +++++
 rtl/image_reflect_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_image_reflect_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared mode constants, controller state type and mode validity check.
// Rotate-180 (mode 11) is accepted only when IMAGE_REFLECT_ROT180_EN is defined.
package image_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_VERT = 2'b01;
    localparam logic [1:0] MODE_HORZ = 2'b10;
    localparam logic [1:0] MODE_ROT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic mode_valid(input logic [1:0] m);
`ifdef IMAGE_REFLECT_ROT180_EN
        return 1'b1;
`else
        return (m != MODE_ROT);
`endif
    endfunction

endpackage

// File: rtl/reflect_out_buf.sv
// Two-entry output FIFO between the RAM read port and the output stream.
// The head entry is presented directly so it stays stable while not popped.
module reflect_out_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/image_reflect_ctrl.sv
// Frame reflection controller: LOAD writes a raster frame into a single-port RAM,
// DRAIN reads it back through mirrored addresses. Mode 11 needs IMAGE_REFLECT_ROT180_EN.
module image_reflect_ctrl
    import image_pkg::*;
#(
    parameter  int ROWS = 512,
    parameter  int COLS = 512,
    parameter  int DW   = 8,
    localparam int AW   = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] COL_MAX   = AW'(COLS - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);
    localparam logic [AW-1:0] LAST_BASE = AW'((ROWS - 1) * COLS);
    localparam logic [AW:0]   NPIX      = (AW + 1)'(ROWS * COLS);

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          s_ready_q, s_ready_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] wr_col_q, wr_col_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [AW-1:0] rd_col_q, rd_col_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic          re_q, re_last_q;

    logic          s_hs, wr_last, vflip, hflip, pop, rd_issue;
    logic [AW-1:0] rd_col_eff, rd_addr, wr_addr;
    logic [2:0]    occ_after;
    logic [1:0]    buf_count;
    logic [DW:0]   buf_head;

    assign s_hs    = (state_q == LOAD) && s_valid && s_ready_q;
    assign wr_last = (wr_base_q == LAST_BASE) && (wr_col_q == COL_MAX);
    assign vflip   = (mode_q == MODE_VERT) || (mode_q == MODE_ROT);
    assign hflip   = (mode_q == MODE_HORZ) || (mode_q == MODE_ROT);
    assign m_valid = (buf_count != 2'd0);
    assign pop     = m_valid && m_ready;

    // A slot freed by this cycle's pop is reusable at once, which keeps 1 pixel/cycle.
    assign occ_after = {1'b0, buf_count} + {2'b00, re_q} - {2'b00, pop};
    assign rd_issue  = (state_q == DRAIN) && (rd_cnt_q != NPIX) &&
                       (buf_count != 2'd2) && (occ_after < 3'd2);

    assign rd_col_eff = hflip ? (COL_MAX - rd_col_q) : rd_col_q;
    assign rd_addr    = rd_base_q + rd_col_eff;
    assign wr_addr    = wr_base_q + wr_col_q;

    assign ram_we    = s_hs;
    assign ram_re    = rd_issue;
    assign ram_addr  = s_hs ? wr_addr : (rd_issue ? rd_addr : '0);
    assign ram_wdata = s_hs ? s_data : '0;

    reflect_out_buf #(.W(DW + 1)) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (re_q),
        .push_data ({re_last_q, ram_rdata}),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign m_data = buf_head[DW-1:0];
    assign m_last = m_valid && buf_head[DW];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        s_ready_d = s_ready_q;
        wr_base_d = wr_base_q;
        wr_col_d  = wr_col_q;
        rd_base_d = rd_base_q;
        rd_col_d  = rd_col_q;
        rd_cnt_d  = rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode_valid(mode)) begin
                        mode_d    = mode;
                        err_d     = 1'b0;
                        state_d   = LOAD;
                        busy_d    = 1'b1;
                        s_ready_d = 1'b1;
                        wr_base_d = '0;
                        wr_col_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_hs) begin
                    if (wr_last) begin
                        state_d   = DRAIN;
                        s_ready_d = 1'b0;
                        wr_base_d = '0;
                        wr_col_d  = '0;
                        rd_cnt_d  = '0;
                        rd_col_d  = '0;
                        rd_base_d = vflip ? LAST_BASE : '0;
                    end else if (wr_col_q == COL_MAX) begin
                        wr_col_d  = '0;
                        wr_base_d = wr_base_q + ROW_STEP;
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_col_q == COL_MAX) begin
                        rd_col_d  = '0;
                        rd_base_d = vflip ? (rd_base_q - ROW_STEP) : (rd_base_q + ROW_STEP);
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end
                if (pop && m_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE_PASS;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            wr_base_q <= '0;
            wr_col_q  <= '0;
            rd_base_q <= '0;
            rd_col_q  <= '0;
            rd_cnt_q  <= '0;
            re_q      <= 1'b0;
            re_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
            wr_base_q <= wr_base_d;
            wr_col_q  <= wr_col_d;
            rd_base_q <= rd_base_d;
            rd_col_q  <= rd_col_d;
            rd_cnt_q  <= rd_cnt_d;
            re_q      <= rd_issue;
            re_last_q <= rd_issue && (rd_cnt_q == NPIX - 1'b1);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign s_ready = s_ready_q;

endmodule

// File: tb/tb_image_reflect_ctrl.sv
// Bench for image_reflect_ctrl on a 4x4 frame: table vectors, hand sequences and
// random frames against a coordinate-mirroring reference. Honors IMAGE_REFLECT_ROT180_EN.
module tb_image_reflect_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst_n, start, s_valid, m_ready;
    logic [1:0]    mode;
    logic [DW-1:0] s_data;
    logic          busy, done, err, s_ready, m_valid, m_last, ram_we, ram_re;
    logic [DW-1:0] m_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    image_reflect_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Frame RAM: synchronous write, read data one cycle after ram_re.
    logic [DW-1:0] ram [N];
    logic [DW-1:0] ram_rdata_r = '0;
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata_r <= ram[ram_addr];
    end
    assign ram_rdata = ram_rdata_r;

    int n_vec = 0;
    int n_bad = 0;
    logic [DW-1:0] pix [N];
    logic [DW-1:0] got_d [$];
    logic          got_l [$];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Output pixel k is input pixel at mirrored (row, col).
    function automatic int ref_pix(input logic [1:0] md, input int k);
        int r, c;
        bit vf, hf;
        r  = k / COLS;
        c  = k % COLS;
        vf = (md == 2'b01) || (md == 2'b11);
        hf = (md == 2'b10) || (md == 2'b11);
        if (vf) r = ROWS - 1 - r;
        if (hf) c = COLS - 1 - c;
        return int'(pix[r * COLS + c]);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " err"}, int'(err), 0);
        check({tag, " s_ready"}, int'(s_ready), 0);
        check({tag, " m_valid"}, int'(m_valid), 0);
        check({tag, " m_last"}, int'(m_last), 0);
        check({tag, " ram_we"}, int'(ram_we), 0);
        check({tag, " ram_re"}, int'(ram_re), 0);
        check({tag, " ram_addr"}, int'(ram_addr), 0);
        check({tag, " ram_wdata"}, int'(ram_wdata), 0);
        check({tag, " m_data"}, int'(m_data), 0);
    endtask

    // bp: 0 = m_ready high, 1 = pattern 1,0,0,1, 2 = random. gaps also adds random
    // input bubbles and spurious start/mode activity. abort_after>0 resets after that output.
    task automatic run_frame(input logic [1:0] md, input int bp, input bit gaps,
                             input int abort_after, input string tag);
        int in_idx = 0, last_in = -1, first_mv = -1, end_cyc = -1;
        int occ = 0, max_occ = 0, stall_bad = 0;
        bit prev_stall = 0, aborted = 0;
        logic [DW-1:0] prev_d = '0;
        got_d.delete();
        got_l.delete();
        @(posedge clk); #1;
        start = 1'b1; mode = md;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, " busy@start"}, int'(busy), 1);
        check({tag, " s_ready@start"}, int'(s_ready), 1);
        check({tag, " err@start"}, int'(err), 0);
        for (int cyc = 0; cyc < 600 && end_cyc < 0 && !aborted; cyc++) begin
            @(posedge clk); #1;
            if (in_idx < N) begin
                s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data  = pix[in_idx];
            end else begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
            end
            case (bp)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
            mode  = gaps ? 2'($urandom_range(0, 3)) : md;
            @(negedge clk);
            if (s_valid && s_ready) begin
                in_idx++;
                last_in = cyc;
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (prev_stall && (!m_valid || m_data !== prev_d)) stall_bad++;
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            occ += int'(ram_re) - int'(m_valid && m_ready);
            if (occ > max_occ) max_occ = occ;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                if (m_last) begin
                    end_cyc = cyc;
                    start   = 1'b1;
                end
                if (got_d.size() == abort_after) begin
                    rst_n   = 1'b0;
                    aborted = 1;
                end
            end
        end
        if (aborted) begin
            #1;
            check_all_zero({tag, " abort"});
            for (int k = 0; k < got_d.size(); k++)
                check({tag, " pre-abort data"}, int'(got_d[k]), ref_pix(md, k));
            start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
            #2 rst_n = 1'b1;
            return;
        end
        if (end_cyc < 0) begin
            check({tag, " frame completes in budget"}, 0, 1);
            return;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, " done pulse"}, int'(done), 1);
        check({tag, " busy after end"}, int'(busy), 0);
        check({tag, " m_valid after end"}, int'(m_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " done one cycle"}, int'(done), 0);
        check({tag, " start at last ignored"}, int'(busy), 0);
        check({tag, " output count"}, got_d.size(), N);
        for (int k = 0; k < got_d.size() && k < N; k++) begin
            check({tag, " data"}, int'(got_d[k]), ref_pix(md, k));
            check({tag, " last"}, int'(got_l[k]), (k == N - 1) ? 1 : 0);
        end
        check({tag, " max occupancy"}, max_occ, 2);
        check({tag, " stable while stalled"}, stall_bad, 0);
        if (bp == 0 && !gaps) begin
            check({tag, " first m_valid latency"}, first_mv - last_in, 3);
            check({tag, " throughput"}, end_cyc - first_mv, N - 1);
        end
    endtask

    typedef struct {
        logic [1:0] md;
        int         bp;
        bit         exp_err;
        int         e0, e1, e2, e3;
        int         elast;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{2'b10, 0, 1'b0, 3, 2, 1, 0, 12};
        tbl[1] = '{2'b01, 0, 1'b0, 12, 13, 14, 15, 3};
        tbl[2] = '{2'b10, 1, 1'b0, 3, 2, 1, 0, 12};
`ifdef IMAGE_REFLECT_ROT180_EN
        tbl[3] = '{2'b11, 0, 1'b0, 15, 14, 13, 12, 0};
`else
        tbl[3] = '{2'b11, 0, 1'b1, 0, 0, 0, 0, 0};
`endif
        tbl[4] = '{2'b00, 0, 1'b0, 0, 1, 2, 3, 15};

        rst_n = 1'b0; start = 1'b0; mode = 2'b00;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #3 rst_n = 1'b1;

        for (int k = 0; k < N; k++) pix[k] = DW'(k);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].exp_err) begin
                @(posedge clk); #1;
                start = 1'b1; mode = tbl[i].md;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                check("invalid mode err", int'(err), 1);
                check("invalid mode busy", int'(busy), 0);
                check("invalid mode s_ready", int'(s_ready), 0);
                repeat (3) @(negedge clk);
                check("invalid mode stays idle", int'(busy), 0);
                check("invalid mode err sticky", int'(err), 1);
            end else begin
                run_frame(tbl[i].md, tbl[i].bp, 1'b0, 0, $sformatf("vec%0d", i));
                if (got_d.size() == N) begin
                    check("tbl out0", int'(got_d[0]), tbl[i].e0);
                    check("tbl out1", int'(got_d[1]), tbl[i].e1);
                    check("tbl out2", int'(got_d[2]), tbl[i].e2);
                    check("tbl out3", int'(got_d[3]), tbl[i].e3);
                    check("tbl out15", int'(got_d[N-1]), tbl[i].elast);
                end
            end
        end

        run_frame(2'b10, 0, 1'b0, 5, "reset mid-drain");
        run_frame(2'b01, 0, 1'b0, 0, "after reset");

        for (int i = 0; i < 6; i++) begin
            logic [1:0] md;
            for (int k = 0; k < N; k++) pix[k] = DW'($urandom);
`ifdef IMAGE_REFLECT_ROT180_EN
            md = 2'($urandom_range(0, 3));
`else
            md = 2'($urandom_range(0, 2));
`endif
            run_frame(md, 2, 1'b1, 0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
